// File: rtl/rv32i_pkg.sv
// Shared RV32I types: register-file widths and the write-back queue entry.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order DEPTH-entry FIFO of write-back entries; also exposes the raw storage
// and per-slot occupancy so the parent can search pending results.
module regfile_wb_fifo
    import rv32i_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic [PTR_W-1:0]      head_ptr,
    output logic [CNT_W-1:0]      count,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]      occupied
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      tail_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Guard against overflow/underflow so a misbehaving parent cannot corrupt the count.
    assign push_ok = push && (count != FULL_COUNT);
    assign pop_ok  = pop && (count != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is not reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    assign head    = mem[head_ptr];
    assign entries = mem;

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset   = '0;
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PTR_W'(i) - head_ptr;
            occupied[i] = (CNT_W'(offset) < count);
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register-file write port, with optional pending-value
// forwarding to decode (built only when REGFILE_WB_FWD_EN is defined).
module regfile_wb_queue
    import rv32i_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [REG_ADDR_W-1:0] IN_RD,
    input  logic [XLEN-1:0]       IN_DATA,
    input  logic                  WR_STALL,
    output logic [REG_ADDR_W-1:0] AW,
    output logic                  EW,
    output logic [XLEN-1:0]       DW,
    input  logic [REG_ADDR_W-1:0] A1,
    input  logic [REG_ADDR_W-1:0] A2,
    output logic                  FWD1_HIT,
    output logic                  FWD2_HIT,
    output logic [XLEN-1:0]       FWD1_DATA,
    output logic [XLEN-1:0]       FWD2_DATA,
    output logic [CNT_W-1:0]      COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    wb_entry_t             in_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      occupied;
    logic [PTR_W-1:0]      head_ptr;
    logic [CNT_W-1:0]      count;
    logic                  accept;
    logic                  push;
    logic                  not_empty;

    // Ready comes from the registered count only, so a full queue never reuses a slot
    // that is being drained in the same cycle.
    assign IN_READY = (count < FULL_COUNT);
    assign accept   = IN_VALID && IN_READY;
    assign push     = accept && (IN_RD != '0);
    assign in_entry = '{rd: IN_RD, data: IN_DATA};

    regfile_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push       (push),
        .push_entry (in_entry),
        .pop        (EW),
        .head       (head),
        .head_ptr   (head_ptr),
        .count      (count),
        .entries    (entries),
        .occupied   (occupied)
    );

    assign not_empty = (count != '0);
    assign EW        = not_empty && !WR_STALL;
    assign AW        = not_empty ? head.rd : '0;
    assign DW        = not_empty ? head.data : '0;
    assign COUNT     = count;

`ifdef REGFILE_WB_FWD_EN
    // Scan oldest to youngest so the last match, the youngest entry, wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        FWD1_HIT  = 1'b0;
        FWD2_HIT  = 1'b0;
        FWD1_DATA = '0;
        FWD2_DATA = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if (occupied[idx] && (A1 != '0) && (entries[idx].rd == A1)) begin
                FWD1_HIT  = 1'b1;
                FWD1_DATA = entries[idx].data;
            end
            if (occupied[idx] && (A2 != '0) && (entries[idx].rd == A2)) begin
                FWD2_HIT  = 1'b1;
                FWD2_DATA = entries[idx].data;
            end
        end
    end
`else
    logic unused_fwd_inputs;

    assign FWD1_HIT          = 1'b0;
    assign FWD2_HIT          = 1'b0;
    assign FWD1_DATA         = '0;
    assign FWD2_DATA         = '0;
    assign unused_fwd_inputs = ^{A1, A2, entries, occupied, head_ptr};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: a reference queue scoreboards every retire,
// and per-scenario tasks check reset, x0 filtering, fill, forwarding, concurrency and reset.
module tb_regfile_wb_queue;
    import rv32i_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              CLK = 1'b0;
    logic              RST;
    logic              IN_VALID;
    logic              IN_READY;
    logic [4:0]        IN_RD;
    logic [31:0]       IN_DATA;
    logic              WR_STALL;
    logic [4:0]        AW;
    logic              EW;
    logic [31:0]       DW;
    logic [4:0]        A1;
    logic [4:0]        A2;
    logic              FWD1_HIT;
    logic              FWD2_HIT;
    logic [31:0]       FWD1_DATA;
    logic [31:0]       FWD2_DATA;
    logic [CNT_W-1:0]  COUNT;

    int        checks   = 0;
    int        failures = 0;
    bit        mon_en   = 1'b0;
    bit        fwd_on;
    logic      mon_exp_ew;
    bit        m_ready;
    bit        m_pop;
    wb_entry_t sb[$];

    regfile_wb_queue #(
        .DEPTH(DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_RD     (IN_RD),
        .IN_DATA   (IN_DATA),
        .WR_STALL  (WR_STALL),
        .AW        (AW),
        .EW        (EW),
        .DW        (DW),
        .A1        (A1),
        .A2        (A2),
        .FWD1_HIT  (FWD1_HIT),
        .FWD2_HIT  (FWD2_HIT),
        .FWD1_DATA (FWD1_DATA),
        .FWD2_DATA (FWD2_DATA),
        .COUNT     (COUNT)
    );

    always #5 CLK = ~CLK;

    // Reference queue: pushes accepted non-x0 results, pops when a retire is due.
    always @(posedge CLK) begin
        if (RST) begin
            sb.delete();
        end else begin
            m_ready = (sb.size() < DEPTH);
            m_pop   = (sb.size() != 0) && !WR_STALL;
            if (m_pop) begin
                void'(sb.pop_front());
            end
            if (IN_VALID && m_ready && (IN_RD != 5'd0)) begin
                sb.push_back('{rd: IN_RD, data: IN_DATA});
            end
        end
    end

    // Mid-cycle monitor: every retire must match the oldest scoreboard entry.
    always @(negedge CLK) begin
        if (mon_en && !RST) begin
            mon_exp_ew = (sb.size() != 0) && !WR_STALL;
            checks++;
            if (EW !== mon_exp_ew) begin
                failures++;
                $display("[TB] FAIL mon_ew: EW=%0b expected %0b at %0t", EW, mon_exp_ew, $time);
            end
            if (mon_exp_ew) begin
                checks++;
                if ((AW !== sb[0].rd) || (DW !== sb[0].data)) begin
                    failures++;
                    $display("[TB] FAIL mon_head: AW=%0d DW=%h expected AW=%0d DW=%h at %0t",
                             AW, DW, sb[0].rd, sb[0].data, $time);
                end
            end
            checks++;
            if (COUNT !== CNT_W'(sb.size())) begin
                failures++;
                $display("[TB] FAIL mon_count: COUNT=%0d expected %0d at %0t", COUNT, sb.size(), $time);
            end
            checks++;
            if (IN_READY !== 1'(sb.size() < DEPTH)) begin
                failures++;
                $display("[TB] FAIL mon_ready: IN_READY=%0b expected %0b at %0t",
                         IN_READY, (sb.size() < DEPTH), $time);
            end
        end
    end

    // Drive one cycle of inputs, let the edge take them, return 1 time unit after it.
    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] d,
                                 input logic st);
        IN_VALID = v;
        IN_RD    = rd;
        IN_DATA  = d;
        WR_STALL = st;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        IN_VALID = 1'b0;
        IN_RD    = 5'd0;
        IN_DATA  = 32'd0;
        WR_STALL = 1'b0;
        A1       = 5'd5;
        A2       = 5'd5;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ((COUNT !== '0) || (EW !== 1'b0) || (AW !== 5'd0) || (DW !== 32'd0)) begin
            failures++;
            $display("[TB] FAIL reset_outputs: COUNT=%0d EW=%0b AW=%0d DW=%h expected 0 0 0 0",
                     COUNT, EW, AW, DW);
        end
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: IN_READY=%0b expected 1", IN_READY);
        end
        checks++;
        if ((FWD1_HIT !== 1'b0) || (FWD2_HIT !== 1'b0) || (FWD1_DATA !== 32'd0) || (FWD2_DATA !== 32'd0)) begin
            failures++;
            $display("[TB] FAIL reset_fwd: hit1=%0b hit2=%0b d1=%h d2=%h expected all 0",
                     FWD1_HIT, FWD2_HIT, FWD1_DATA, FWD2_DATA);
        end
        RST    = 1'b0;
        A1     = 5'd0;
        A2     = 5'd0;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        checks++;
        if ((EW !== 1'b1) || (AW !== 5'd5) || (DW !== 32'hDEADBEEF)) begin
            failures++;
            $display("[TB] FAIL single_retire: EW=%0b AW=%0d DW=%h expected 1 5 deadbeef", EW, AW, DW);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if ((EW !== 1'b0) || (COUNT !== '0)) begin
            failures++;
            $display("[TB] FAIL single_drained: EW=%0b COUNT=%0d expected 0 0", EW, COUNT);
        end
    endtask

    task automatic test_x0_filter();
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL x0_ready: IN_READY=%0b expected 1", IN_READY);
        end
        applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0);
        checks++;
        if ((COUNT !== '0) || (EW !== 1'b0)) begin
            failures++;
            $display("[TB] FAIL x0_dropped: COUNT=%0d EW=%0b expected 0 0", COUNT, EW);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if (EW !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_no_write: EW=%0b expected 0", EW);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 5'(i), 32'hA0 + i, 1'b1);
        end
        checks++;
        if ((COUNT !== CNT_W'(DEPTH)) || (IN_READY !== 1'b0) || (EW !== 1'b0)) begin
            failures++;
            $display("[TB] FAIL fill_full: COUNT=%0d IN_READY=%0b EW=%0b expected %0d 0 0",
                     COUNT, IN_READY, EW, DEPTH);
        end
        applyStimulus(1'b1, 5'd9, 32'h0BAD, 1'b1);
        checks++;
        if (COUNT !== CNT_W'(DEPTH)) begin
            failures++;
            $display("[TB] FAIL fill_reject: COUNT=%0d expected %0d", COUNT, DEPTH);
        end
        WR_STALL = 1'b0;
        #1;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if ((EW !== 1'b1) || (AW !== 5'(i)) || (DW !== 32'hA0 + i)) begin
                failures++;
                $display("[TB] FAIL fill_order: EW=%0b AW=%0d DW=%h expected 1 %0d %h",
                         EW, AW, DW, i, 32'hA0 + i);
            end
            if (i == 1) begin
                checks++;
                if (IN_READY !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL fill_no_reuse: IN_READY=%0b expected 0", IN_READY);
                end
            end
            applyStimulus(1'(i == 1), 5'd9, 32'h0BAD, 1'b0);
        end
        checks++;
        if ((EW !== 1'b0) || (COUNT !== '0)) begin
            failures++;
            $display("[TB] FAIL fill_drained: EW=%0b COUNT=%0d expected 0 0", EW, COUNT);
        end
    endtask

    task automatic test_forward();
        logic [31:0] exp_d;
        exp_d    = fwd_on ? 32'h22 : 32'h0;
        IN_VALID = 1'b1;
        IN_RD    = 5'd12;
        IN_DATA  = 32'h55;
        A1       = 5'd12;
        #1;
        checks++;
        if (FWD1_HIT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fwd_in_bus: FWD1_HIT=%0b expected 0", FWD1_HIT);
        end
        IN_VALID = 1'b0;
        A1       = 5'd0;
        applyStimulus(1'b1, 5'd7, 32'h11, 1'b1);
        applyStimulus(1'b1, 5'd7, 32'h22, 1'b1);
        A1 = 5'd7;
        A2 = 5'd0;
        #1;
        checks++;
        if ((FWD1_HIT !== 1'(fwd_on)) || (FWD1_DATA !== exp_d)) begin
            failures++;
            $display("[TB] FAIL fwd_youngest: hit=%0b data=%h expected %0b %h", FWD1_HIT, FWD1_DATA, fwd_on, exp_d);
        end
        checks++;
        if ((FWD2_HIT !== 1'b0) || (FWD2_DATA !== 32'd0)) begin
            failures++;
            $display("[TB] FAIL fwd_x0: hit=%0b data=%h expected 0 0", FWD2_HIT, FWD2_DATA);
        end
        A2 = 5'd7;
        #1;
        checks++;
        if ((FWD2_HIT !== 1'(fwd_on)) || (FWD2_DATA !== exp_d)) begin
            failures++;
            $display("[TB] FAIL fwd_port2: hit=%0b data=%h expected %0b %h", FWD2_HIT, FWD2_DATA, fwd_on, exp_d);
        end
        A2 = 5'd3;
        #1;
        checks++;
        if (FWD2_HIT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fwd_miss: hit=%0b expected 0", FWD2_HIT);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if ((FWD1_HIT !== 1'(fwd_on)) || (FWD1_DATA !== exp_d)) begin
            failures++;
            $display("[TB] FAIL fwd_after_pop: hit=%0b data=%h expected %0b %h", FWD1_HIT, FWD1_DATA, fwd_on, exp_d);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if ((FWD1_HIT !== 1'b0) || (FWD1_DATA !== 32'd0)) begin
            failures++;
            $display("[TB] FAIL fwd_empty: hit=%0b data=%h expected 0 0", FWD1_HIT, FWD1_DATA);
        end
        A1 = 5'd0;
        A2 = 5'd0;
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 5'd10, 32'h100, 1'b1);
        applyStimulus(1'b1, 5'd11, 32'h101, 1'b1);
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (AW !== 5'(10 + j)) begin
                failures++;
                $display("[TB] FAIL b2b_head: AW=%0d expected %0d", AW, 10 + j);
            end
            applyStimulus(1'b1, 5'(12 + j), 32'h102 + j, 1'b0);
            checks++;
            if (COUNT !== CNT_W'(2)) begin
                failures++;
                $display("[TB] FAIL b2b_count: COUNT=%0d expected 2", COUNT);
            end
        end
        checks++;
        if ((AW !== 5'd16) || (DW !== 32'h106)) begin
            failures++;
            $display("[TB] FAIL b2b_tail1: AW=%0d DW=%h expected 16 106", AW, DW);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if ((AW !== 5'd17) || (DW !== 32'h107)) begin
            failures++;
            $display("[TB] FAIL b2b_tail2: AW=%0d DW=%h expected 17 107", AW, DW);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checks++;
        if (COUNT !== '0) begin
            failures++;
            $display("[TB] FAIL b2b_drained: COUNT=%0d expected 0", COUNT);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(20 + i), 32'h200 + i, 1'b1);
        end
        checks++;
        if (COUNT !== CNT_W'(3)) begin
            failures++;
            $display("[TB] FAIL midrst_pre: COUNT=%0d expected 3", COUNT);
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        checks++;
        if ((COUNT !== '0) || (EW !== 1'b0) || (IN_READY !== 1'b1)) begin
            failures++;
            $display("[TB] FAIL midrst_state: COUNT=%0d EW=%0b IN_READY=%0b expected 0 0 1", COUNT, EW, IN_READY);
        end
        WR_STALL = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (EW !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midrst_no_write: EW=%0b AW=%0d expected EW 0", EW, AW);
            end
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        end
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0);
        checks++;
        if ((EW !== 1'b1) || (AW !== 5'd3) || (DW !== 32'h33)) begin
            failures++;
            $display("[TB] FAIL midrst_resume: EW=%0b AW=%0d DW=%h expected 1 3 33", EW, AW, DW);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
`ifdef REGFILE_WB_FWD_EN
        fwd_on = 1'b1;
`else
        fwd_on = 1'b0;
`endif
        $display("[TB] start, forwarding built=%0b", fwd_on);
        test_reset();
        test_single();
        test_x0_filter();
        test_fill();
        test_forward();
        test_back_to_back();
        test_mid_reset();
        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
